cv_ctrl_port: RTL and testbench

//  Controller port stage downstream of the address decoder. Consumes ctrl_en_key_n/ctrl_en_joy_n
//  (mode select writes, 0x80/0xC0) and ctrl_r_n (reads, 0xFC/0xFF). Returns active-low

---
 rtl/cv_ctrl_pkg.sv | 24 ++
 rtl/cv_ctrl_port_spin.sv | 56 +++++
 rtl/cv_ctrl_port.sv | 116 +++++++++++
 tb/tb_cv_ctrl_port.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cv_ctrl_pkg.sv
// Shared types and key-code table for the controller port slice.
package cv_ctrl_pkg;

    typedef enum logic {KEYPAD = 1'b0, JOYSTICK = 1'b1} mode_t;

    localparam logic [3:0] KEY_NONE   = 4'hF;
    localparam logic [3:0] SAC_PURPLE = 4'h8;
    localparam logic [3:0] SAC_BLUE   = 4'h4;

    // Indexed by key number: 0..9, then *, then #
    localparam logic [0:11][3:0] KEY_CODE = {
        4'hA, 4'hD, 4'h7, 4'hC, 4'h2, 4'h3, 4'hE, 4'h5, 4'h1, 4'hB, 4'h6, 4'h9
    };

    // Lowest pressed key index wins
    function automatic logic [3:0] key_encode(input logic [11:0] keys);
        logic [3:0] code;
        code = KEY_NONE;
        for (int i = 11; i >= 0; i--)
            if (keys[i]) code = KEY_CODE[i];
        return code;
    endfunction

endpackage

// File: rtl/cv_ctrl_port_spin.sv
// Per-player spinner stepper: saturating delta accumulator drained one quadrature
// step per divider wrap, with the direction level of the last step.
module cv_spin_stepper #(
    parameter int STEP_DIV = 1024,
    parameter int ACC_W    = 10
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic [7:0] delta_i,
    input  logic       stb_i,
    output logic       dir_o,
    output logic       step_o
);
    localparam int CNT_W = $clog2(STEP_DIV);
    localparam int SUM_W = ACC_W + 9;
    localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'(2 ** (ACC_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] ONE     = ACC_W'(1);

    logic [CNT_W-1:0]        cnt_q;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [SUM_W-1:0] sum;
    logic                    dir_q, dir_d, wrap;

    assign wrap = (cnt_q == CNT_W'(STEP_DIV - 1));

    // Delta lands first so a same-cycle step drains the updated value
    always_comb begin
        sum = SUM_W'(acc_q);
        if (stb_i) sum = sum + SUM_W'($signed(delta_i));
        if (sum > ACC_MAX)       sum = ACC_MAX;
        else if (sum < -ACC_MAX) sum = -ACC_MAX;
        acc_d  = sum[ACC_W-1:0];
        dir_d  = dir_q;
        step_o = 1'b0;
        if (wrap && acc_d != '0) begin
            step_o = 1'b1;
            dir_d  = ~acc_d[ACC_W-1];
            acc_d  = acc_d[ACC_W-1] ? acc_d + ONE : acc_d - ONE;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q <= '0;
            acc_q <= '0;
            dir_q <= 1'b1;
        end else begin
            cnt_q <= wrap ? '0 : cnt_q + CNT_W'(1);
            acc_q <= acc_d;
            dir_q <= dir_d;
        end
    end

    assign dir_o = dir_q;

endmodule

// File: rtl/cv_ctrl_port.sv
// Controller port: mode select, synchronised pad reads and spinner interrupt.
// Define CV_CTRL_SAC_EN to map Super Action arm buttons onto keypad codes 8/4.
module cv_ctrl_port
    import cv_ctrl_pkg::*;
#(
    parameter int STEP_DIV = 1024,
    parameter int ACC_W    = 10
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             ctrl_en_key_n_i,
    input  logic             ctrl_en_joy_n_i,
    input  logic             ctrl_r_n_i,
    input  logic             a1_i,
    input  logic [1:0][5:0]  joy_i,
    input  logic [1:0][11:0] key_i,
    input  logic [1:0][1:0]  sac_btn_i,
    input  logic [1:0][7:0]  spin_delta_i,
    input  logic [1:0]       spin_stb_i,
    output logic [7:0]       d_o,
    output logic             int_n_o
);
    logic [1:0][5:0]  joy_s1, joy_s2;
    logic [1:0][11:0] key_s1, key_s2;
    logic [1:0][7:0]  rd_byte;
    logic [1:0]       dir, step, pend_q, pend_d, clr;
    logic             key_n_q, joy_n_q, r_n_q, r_fall;
    mode_t            mode_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            joy_s1 <= '0;
            joy_s2 <= '0;
            key_s1 <= '0;
            key_s2 <= '0;
        end else begin
            joy_s1 <= joy_i;
            joy_s2 <= joy_s1;
            key_s1 <= key_i;
            key_s2 <= key_s1;
        end
    end

`ifdef CV_CTRL_SAC_EN
    logic [1:0][1:0] sac_s1, sac_s2;
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sac_s1 <= '0;
            sac_s2 <= '0;
        end else begin
            sac_s1 <= sac_btn_i;
            sac_s2 <= sac_s1;
        end
    end
`else
    logic sac_unused;
    assign sac_unused = ^sac_btn_i;
`endif

    for (genvar p = 0; p < 2; p++) begin : g_plr
        logic [3:0] code;
        logic [7:0] rd_c;

        cv_spin_stepper #(.STEP_DIV(STEP_DIV), .ACC_W(ACC_W)) u_spin (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .delta_i   (spin_delta_i[p]),
            .stb_i     (spin_stb_i[p]),
            .dir_o     (dir[p]),
            .step_o    (step[p])
        );

        always_comb begin
            code = key_encode(key_s2[p]);
`ifdef CV_CTRL_SAC_EN
            if (code == KEY_NONE) begin
                if (sac_s2[p][0])      code = SAC_PURPLE;
                else if (sac_s2[p][1]) code = SAC_BLUE;
            end
`endif
            if (mode_q == JOYSTICK)
                rd_c = {1'b1, ~joy_s2[p][4], 1'b1, dir[p], ~joy_s2[p][3:0]};
            else
                rd_c = {1'b1, ~joy_s2[p][5], 1'b1, dir[p], code};
        end

        assign rd_byte[p] = rd_c;
    end

    assign r_fall = r_n_q & ~ctrl_r_n_i;
    assign clr    = {r_fall & a1_i, r_fall & ~a1_i};
    // A step arriving with the clear keeps the request alive
    assign pend_d = step | (pend_q & ~clr);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            key_n_q <= 1'b1;
            joy_n_q <= 1'b1;
            r_n_q   <= 1'b1;
            mode_q  <= KEYPAD;
            pend_q  <= '0;
            d_o     <= 8'hFF;
        end else begin
            key_n_q <= ctrl_en_key_n_i;
            joy_n_q <= ctrl_en_joy_n_i;
            r_n_q   <= ctrl_r_n_i;
            pend_q  <= pend_d;
            if (joy_n_q && !ctrl_en_joy_n_i)      mode_q <= JOYSTICK;
            else if (key_n_q && !ctrl_en_key_n_i) mode_q <= KEYPAD;
            if (!ctrl_r_n_i) d_o <= rd_byte[a1_i];
        end
    end

    assign int_n_o = ~|pend_q;

endmodule

// File: tb/tb_cv_ctrl_port.sv
// Directed bench for cv_ctrl_port with a read-data scoreboard (STEP_DIV=4, ACC_W=8).
module tb_cv_ctrl_port;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             ctrl_en_key_n, ctrl_en_joy_n, ctrl_r_n, a1;
    logic [1:0][5:0]  joy;
    logic [1:0][11:0] key;
    logic [1:0][1:0]  sac;
    logic [1:0][7:0]  spin_delta;
    logic [1:0]       spin_stb;
    logic [7:0]       d_o;
    logic             int_n;

    int         n_cmp, n_err, steps;
    logic [7:0] first_rd;
    logic [7:0] exp_q[$];

`ifdef CV_CTRL_SAC_EN
    localparam logic [7:0] SAC_P = 8'hF8;
    localparam logic [7:0] SAC_B = 8'hF4;
`else
    localparam logic [7:0] SAC_P = 8'hFF;
    localparam logic [7:0] SAC_B = 8'hFF;
`endif

    cv_ctrl_port #(.STEP_DIV(4), .ACC_W(8)) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .ctrl_en_key_n_i (ctrl_en_key_n),
        .ctrl_en_joy_n_i (ctrl_en_joy_n),
        .ctrl_r_n_i      (ctrl_r_n),
        .a1_i            (a1),
        .joy_i           (joy),
        .key_i           (key),
        .sac_btn_i       (sac),
        .spin_delta_i    (spin_delta),
        .spin_stb_i      (spin_stb),
        .d_o             (d_o),
        .int_n_o         (int_n)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic settle();
        repeat (3) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h, wanted %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic a, input logic [7:0] exp, input string tag);
        ctrl_r_n = 1'b0;
        a1 = a;
        exp_q.push_back(exp);
        tick();
        chk(tag, {24'd0, d_o}, {24'd0, exp_q.pop_front()});
        ctrl_r_n = 1'b1;
        tick();
    endtask

    task automatic strobe(input logic k, input logic j);
        ctrl_en_key_n = ~k;
        ctrl_en_joy_n = ~j;
        tick();
        ctrl_en_key_n = 1'b1;
        ctrl_en_joy_n = 1'b1;
        tick();
    endtask

    task automatic clear_inputs();
        ctrl_en_key_n = 1'b1; ctrl_en_joy_n = 1'b1; ctrl_r_n = 1'b1; a1 = 1'b0;
        joy = '0; key = '0; sac = '0; spin_delta = '0; spin_stb = '0;
    endtask

    // Acknowledge each P1 interrupt with a read; records the byte read after the first step
    task automatic count_steps(input int cycles, output int n, output logic [7:0] first);
        n = 0;
        first = 8'h00;
        for (int c = 0; c < cycles; c++) begin
            if (!ctrl_r_n) begin
                if (n == 1) first = d_o;
                ctrl_r_n = 1'b1;
            end else if (!int_n) begin
                ctrl_r_n = 1'b0;
                a1 = 1'b0;
                n++;
            end
            tick();
        end
        ctrl_r_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) tick();
        chk("rst_d", {24'd0, d_o}, 32'hFF);
        chk("rst_int", {31'd0, int_n}, 32'd1);
        reset_n = 1'b1;
        tick();

        rd(1'b0, 8'hFF, "idle_fc");
        rd(1'b1, 8'hFF, "idle_ff");

        key[0] = 12'h020; settle();
        rd(1'b0, 8'hF3, "key5");
        key[0] = 12'h024; settle();
        rd(1'b0, 8'hF7, "key2_beats_5");
        joy[0] = 6'b100000; settle();
        rd(1'b0, 8'hB7, "key2_fire_r");
        joy[0] = '0; key[0] = '0;
        key[1] = 12'hC00; settle();
        rd(1'b1, 8'hF6, "star_beats_hash");
        key[1] = 12'h800; settle();
        rd(1'b1, 8'hF9, "hash");
        key[1] = 12'h001; settle();
        rd(1'b1, 8'hFA, "key0");
        key[1] = '0;

        strobe(1'b0, 1'b1);
        joy[1] = 6'b010001; settle();
        rd(1'b1, 8'hBE, "joy_p2_up_firel");
        rd(1'b0, 8'hFF, "joy_p1_idle");
        key[0] = 12'h020; settle();
        rd(1'b0, 8'hFF, "joy_ignores_keys");
        joy[0] = 6'b001010; settle();
        rd(1'b0, 8'hF5, "joy_left_right");
        strobe(1'b1, 1'b0);
        rd(1'b0, 8'hF3, "back_to_keypad");
        strobe(1'b1, 1'b1);
        rd(1'b0, 8'hF5, "both_strobes_joy_wins");

        strobe(1'b1, 1'b0);
        joy = '0; key = '0;
        sac[0] = 2'b01; settle();
        rd(1'b0, SAC_P, "sac_purple");
        sac[0] = 2'b11; settle();
        rd(1'b0, SAC_P, "sac_purple_beats_blue");
        sac[0] = 2'b10; settle();
        rd(1'b0, SAC_B, "sac_blue");
        key[0] = 12'h020; settle();
        rd(1'b0, 8'hF3, "key_beats_sac");
        sac = '0; key = '0;

        strobe(1'b0, 1'b1);
        joy[0] = 6'b000001; settle();
        rd(1'b0, 8'hFE, "joy_up_pre_rst");
        reset_n = 1'b0;
        #1;
        chk("async_rst_d", {24'd0, d_o}, 32'hFF);
        tick();
        reset_n = 1'b1;
        clear_inputs();
        key[0] = 12'h020; settle();
        rd(1'b0, 8'hF3, "rst_mode_keypad");

        // Spinner: +3 gives steps at the divider wraps on edges 4, 8 and 12 after release
        reset_n = 1'b0;
        clear_inputs();
        tick();
        reset_n = 1'b1;
        spin_stb[0] = 1'b1; spin_delta[0] = 8'd3;
        tick();
        spin_stb[0] = 1'b0; spin_delta[0] = '0;
        tick(); tick();
        chk("spin_no_early_int", {31'd0, int_n}, 32'd1);
        tick();
        chk("spin_step1_int", {31'd0, int_n}, 32'd0);
        ctrl_r_n = 1'b0; a1 = 1'b1;
        tick();
        chk("spin_p2_read_keeps_int", {31'd0, int_n}, 32'd0);
        ctrl_r_n = 1'b1;
        tick();
        ctrl_r_n = 1'b0; a1 = 1'b0;
        exp_q.push_back(8'hFF);
        tick();
        chk("spin_rd_dir_pos", {24'd0, d_o}, {24'd0, exp_q.pop_front()});
        chk("spin_clr1", {31'd0, int_n}, 32'd1);
        ctrl_r_n = 1'b1;
        tick();
        chk("spin_step2_int", {31'd0, int_n}, 32'd0);
        ctrl_r_n = 1'b0;
        tick();
        chk("spin_clr2", {31'd0, int_n}, 32'd1);
        ctrl_r_n = 1'b1;
        tick(); tick();
        ctrl_r_n = 1'b0;
        tick();
        chk("spin_step3_set_wins", {31'd0, int_n}, 32'd0);
        ctrl_r_n = 1'b1;
        tick();
        ctrl_r_n = 1'b0;
        tick();
        chk("spin_clr3", {31'd0, int_n}, 32'd1);
        ctrl_r_n = 1'b1;
        repeat (12) tick();
        chk("spin_acc_zero_no_int", {31'd0, int_n}, 32'd1);

        // Saturation: +127 twice holds at 127 (a wrapped sum would step negative twice)
        reset_n = 1'b0;
        clear_inputs();
        tick();
        reset_n = 1'b1;
        spin_stb[0] = 1'b1; spin_delta[0] = 8'h7F;
        tick(); tick();
        spin_stb[0] = 1'b0; spin_delta[0] = '0;
        exp_q.push_back(8'hFF);
        count_steps(560, steps, first_rd);
        chk("sat_first_dir", {24'd0, first_rd}, {24'd0, exp_q.pop_front()});
        chk("sat_step_count", steps, 32'd127);

        spin_stb[0] = 1'b1; spin_delta[0] = 8'hFE;
        tick();
        spin_stb[0] = 1'b0; spin_delta[0] = '0;
        exp_q.push_back(8'hEF);
        count_steps(40, steps, first_rd);
        chk("neg_dir_zero", {24'd0, first_rd}, {24'd0, exp_q.pop_front()});
        chk("neg_step_count", steps, 32'd2);
        chk("neg_int_idle", {31'd0, int_n}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
